// File: rtl/mio_arb_pkg.sv
// Shared encodings for the CPU/display memory-port arbiter: FSM states and grant codes.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DSP  = 2'b10;

endpackage

// File: rtl/mio_arb_pick.sv
// Combinational winner selection between the CPU and the display fetch engine.
module mio_arb_pick
    import mio_arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       dsp_req,
    input  logic       starve_hit,
    input  logic       rr_ptr,
    output logic [1:0] win
);

    // On contention the display wins only when starved or when the round-robin pointer favours it.
    always_comb begin
        win = GNT_NONE;
        if (cpu_req && dsp_req) begin
            win = (starve_hit || rr_ptr) ? GNT_DSP : GNT_CPU;
        end else if (cpu_req) begin
            win = GNT_CPU;
        end else if (dsp_req) begin
            win = GNT_DSP;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one fixed-latency memory port between the CPU and the display engine.
// Define ARB_ROUND_ROBIN_EN to alternate winners on contention instead of CPU priority.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int DSP_MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dsp_req,
    input  logic [31:0] dsp_addr,
    output logic [31:0] dsp_rdata,
    output logic        dsp_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] STARVE_MAX = 8'(DSP_MAX_WAIT);
    localparam logic [2:0] LAT_LAST   = 3'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    arb_state_t  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        txn_we_q, txn_we_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dsp_ready_q, dsp_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dsp_rdata_q, dsp_rdata_d;

    logic        starve_hit;
    logic        rr_sel;
    logic [1:0]  pick_win;
    logic        done_rd;

    assign starve_hit = !RR_EN && (starve_cnt_q == STARVE_MAX);
    assign rr_sel     = RR_EN && rr_ptr_q;

    mio_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dsp_req    (dsp_req),
        .starve_hit (starve_hit),
        .rr_ptr     (rr_sel),
        .win        (pick_win)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        txn_we_d     = txn_we_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        cpu_ready_d  = 1'b0;
        dsp_ready_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dsp_rdata_d  = dsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_win == GNT_CPU) begin
                    state_d     = ACCESS;
                    grant_d     = GNT_CPU;
                    txn_we_d    = cpu_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                end else if (pick_win == GNT_DSP) begin
                    state_d    = ACCESS;
                    grant_d    = GNT_DSP;
                    txn_we_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = dsp_addr;
                end
                // A requesting display that did not win this cycle has been refused once more.
                if (pick_win == GNT_DSP) begin
                    starve_cnt_d = '0;
                end else if (dsp_req && (starve_cnt_q != STARVE_MAX)) begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
            ACCESS: begin
                if (MEM_LAT == 1) begin
                    state_d     = DONE;
                    cpu_ready_d = (grant_q == GNT_CPU);
                    dsp_ready_d = (grant_q == GNT_DSP);
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = '0;
                end
            end
            WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d     = DONE;
                    cpu_ready_d = (grant_q == GNT_CPU);
                    dsp_ready_d = (grant_q == GNT_DSP);
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = GNT_NONE;
                rr_ptr_d = (grant_q == GNT_CPU);
                if (!txn_we_q && (grant_q == GNT_CPU)) cpu_rdata_d = mem_rdata;
                if (!txn_we_q && (grant_q == GNT_DSP)) dsp_rdata_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_NONE;
            txn_we_q     <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            rr_ptr_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            dsp_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            dsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            txn_we_q     <= txn_we_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ready_q  <= cpu_ready_d;
            dsp_ready_q  <= dsp_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dsp_rdata_q  <= dsp_rdata_d;
        end
    end

    // Read data is only valid during DONE, so it is forwarded there to line up with the ready pulse.
    assign done_rd   = (state_q == DONE) && !txn_we_q;
    assign cpu_rdata = (done_rd && (grant_q == GNT_CPU)) ? mem_rdata : cpu_rdata_q;
    assign dsp_rdata = (done_rd && (grant_q == GNT_DSP)) ? mem_rdata : dsp_rdata_q;

    assign cpu_ready = cpu_ready_q;
    assign dsp_ready = dsp_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign dbg_state = state_q;

endmodule
